// File: rtl/io_hex_pkg.sv
// io_hex_pkg: types and constants shared by the hex/decimal display block.
//   hexdisp_state_t : converter FSM states
//   SEG_BLANK       : active-low code with every segment off
//   SEG_LUT         : active-low {g,f,e,d,c,b,a} codes for nibble values 0..F
package io_hex_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } hexdisp_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/io_hex_display_if.sv
// io_hex_display_if: CPU IO-register side of the hex display.
//   io_data  : value written to the IO output register
//   io_we    : one-cycle write strobe for io_data
//   mode_dec : 0 = hex display, 1 = decimal display
//   busy     : conversion in progress
//   ovf      : decimal value did not fit in eight digits
// master = CPU side, slave = display side.
interface io_hex_display_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] io_data;
  logic             io_we;
  logic             mode_dec;
  logic             busy;
  logic             ovf;

  modport master (output io_data, output io_we, output mode_dec,
                  input  busy,    input  ovf);
  modport slave  (input  io_data, input  io_we, input  mode_dec,
                  output busy,    output ovf);
endinterface

// File: rtl/io_hex_display_seg7_decode.sv
// seg7_decode: combinational nibble to active-low 7-segment code.
//   nib_i   : digit value 0..F
//   blank_i : 1 forces all segments off
//   seg_o   : {g,f,e,d,c,b,a}, active low
module seg7_decode
  import io_hex_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = blank_i ? SEG_BLANK : SEG_LUT[nib_i];
  end

endmodule

// File: rtl/io_hex_display.sv
// io_hex_display: drives HEX7..HEX0 from the CPU IO output register.
// Hex mode shows the raw word; decimal mode converts it to BCD with an
// iterative double-dabble (one shift per cycle) before display.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : io_hex_display_if slave (io_data, io_we, mode_dec, busy, ovf)
//   HEX0..HEX7 : registered active-low segment codes, HEX0 least significant
module io_hex_display
  import io_hex_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int BCD_DIGITS    = 10,
  parameter int BLANK_LEADING = 1
) (
  input  logic             clk,
  input  logic             rst,
  io_hex_display_if.slave  bus,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [6:0]       HEX4,
  output logic [6:0]       HEX5,
  output logic [6:0]       HEX6,
  output logic [6:0]       HEX7
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  hexdisp_state_t   state_q, state_d;
  logic [WIDTH-1:0] bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_q, dec_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_data_q, pend_data_d;
  logic             ovf_q, ovf_d;
  logic [6:0]       hex_q [8];
  logic [6:0]       hex_d [8];
  logic [6:0]       seg   [8];
  logic             ovf_dig;

  // Per-nibble add-3; nibbles are independent, no carry between them.
  function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Digit selection and decode. The decoders run continuously but their
  // outputs are only captured in DONE, so HEXn never shows partial results.
  for (genvar k = 0; k < 8; k++) begin : g_dig
    logic [3:0] nib;
    logic       blank;
    assign nib = dec_q ? 4'(bcd_q >> (4*k)) : 4'(bin_sr_q >> (4*k));
    if (k == 0) begin : g_lsd
      assign blank = 1'b0;
    end else begin : g_hi
      // Leading-zero blank: this digit and all higher shown digits are zero.
      assign blank = (BLANK_LEADING != 0) && dec_q &&
                     ((32'(bcd_q) >> (4*k)) == 32'd0);
    end
    seg7_decode u_dec (.nib_i(nib), .blank_i(blank), .seg_o(seg[k]));
  end

  if (BCD_DIGITS > 8) begin : g_ovf
    assign ovf_dig = |bcd_q[BCD_W-1:32];
  end else begin : g_no_ovf
    assign ovf_dig = 1'b0;
  end

  always_comb begin
    logic [BCD_W+WIDTH-1:0] sh;
    sh          = '0;
    state_d     = state_q;
    bin_sr_d    = bin_sr_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    dec_d       = dec_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    ovf_d       = ovf_q;
    hex_d       = hex_q;

    case (state_q)
      IDLE: begin
        // A fresh write wins over a queued one.
        if (bus.io_we || pend_q) begin
          bin_sr_d = bus.io_we ? bus.io_data : pend_data_q;
          dec_d    = bus.mode_dec;
          pend_d   = 1'b0;
          if (bus.mode_dec) begin
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        sh                = {add3_all(bcd_q), bin_sr_q} << 1;
        {bcd_d, bin_sr_d} = sh;
        cnt_d             = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        hex_d   = seg;
        ovf_d   = dec_q & ovf_dig;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Writes arriving mid-conversion park in a single-entry buffer.
    if (state_q != IDLE && bus.io_we) begin
      pend_d      = 1'b1;
      pend_data_d = bus.io_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < 8; k++) hex_q[k] <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      hex_q   <= hex_d;
    end
  end

  always_ff @(posedge clk) begin
    bin_sr_q    <= bin_sr_d;
    bcd_q       <= bcd_d;
    pend_data_q <= pend_data_d;
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.ovf  = ovf_q;

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];
  assign HEX6 = hex_q[6];
  assign HEX7 = hex_q[7];

endmodule

// File: tb/tb_io_hex_display.sv
// tb_io_hex_display: directed and randomized checks of io_hex_display
// against an arithmetic model of the expected display contents.
module tb_io_hex_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] h0, h1, h2, h3, h4, h5, h6, h7;

  io_hex_display_if #(.WIDTH(32)) bus ();

  io_hex_display #(.WIDTH(32), .BCD_DIGITS(10), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3),
    .HEX4(h4), .HEX5(h5), .HEX6(h6), .HEX7(h7)
  );

  always #5 clk = ~clk;

  localparam logic [6:0]  LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  localparam logic [55:0] ALL_BLANK = {8{7'h7F}};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected {HEX7..HEX0} from the value and mode, using decimal arithmetic.
  function automatic logic [55:0] model_disp(input logic [31:0] v, input bit dec);
    logic [55:0] r;
    logic [63:0] m, p, d;
    r = '0;
    if (!dec) begin
      for (int k = 0; k < 8; k++) r[7*k +: 7] = LUT[v[4*k +: 4]];
    end else begin
      m = {32'd0, v} % 64'd100000000;
      p = 64'd1;
      for (int k = 0; k < 8; k++) begin
        d = (m / p) % 64'd10;
        if (k > 0 && m < p) r[7*k +: 7] = 7'h7F;
        else                r[7*k +: 7] = LUT[d[3:0]];
        p = p * 64'd10;
      end
    end
    return r;
  endfunction

  function automatic logic model_ovf(input logic [31:0] v, input bit dec);
    return dec && (v >= 32'd100000000);
  endfunction

  function automatic logic [55:0] disp();
    return {h7, h6, h5, h4, h3, h2, h1, h0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] v, input bit dec);
    bus.io_data  = v;
    bus.io_we    = 1'b1;
    bus.mode_dec = dec;
    tick();
    bus.io_we    = 1'b0;
  endtask

  // Count busy cycles (bounded) and note whether the display moved meanwhile.
  task automatic wait_idle(input logic [55:0] hold, output int n, output bit stable);
    n = 0;
    stable = 1'b1;
    while (bus.busy === 1'b1 && n < 200) begin
      if (disp() !== hold) stable = 1'b0;
      n++;
      tick();
    end
  endtask

  logic [55:0] cur;
  int          n;
  bit          stable;

  task automatic run_one(input string tag, input logic [31:0] v, input bit dec);
    do_write(v, dec);
    wait_idle(cur, n, stable);
    check_eq({tag, "_busy"}, 64'(n), dec ? 64'd33 : 64'd1);
    check_eq({tag, "_hold"}, 64'(stable), 64'd1);
    check_eq({tag, "_disp"}, 64'(disp()), 64'(model_disp(v, dec)));
    check_eq({tag, "_ovf"}, 64'(bus.ovf), 64'(model_ovf(v, dec)));
    cur = model_disp(v, dec);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v1, v2;
    bit          m2;
    int          t;

    rst = 1'b1;
    bus.io_we = 1'b0;
    bus.io_data = '0;
    bus.mode_dec = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_eq("rst_disp", 64'(disp()), 64'(ALL_BLANK));
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_ovf", 64'(bus.ovf), 64'd0);
    cur = ALL_BLANK;

    run_one("hex_deadbeef", 32'hDEADBEEF, 1'b0);
    check_eq("hex_deadbeef_const", 64'(disp()),
             64'({7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}));
    run_one("dec_12345678", 32'd12345678, 1'b1);
    check_eq("dec_12345678_const", 64'(disp()),
             64'({7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}));
    run_one("dec_ffffffff", 32'hFFFFFFFF, 1'b1);
    run_one("dec_7", 32'd7, 1'b1);
    run_one("dec_0", 32'd0, 1'b1);
    run_one("dec_1e8", 32'd100000000, 1'b1);
    run_one("dec_1e8m1", 32'd99999999, 1'b1);

    // Reset mid-conversion.
    do_write(32'd4242, 1'b1);
    repeat (10) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check_eq("midrst_disp", 64'(disp()), 64'(ALL_BLANK));
    check_eq("midrst_busy", 64'(bus.busy), 64'd0);
    check_eq("midrst_ovf", 64'(bus.ovf), 64'd0);
    cur = ALL_BLANK;

    // Pending writes: 100 shown, then only the last write (9) converted.
    do_write(32'd100, 1'b1);
    repeat (4) tick();
    do_write(32'd5, 1'b1);
    repeat (4) tick();
    do_write(32'd9, 1'b1);
    wait_idle(cur, n, stable);
    check_eq("pend_first_busy", 64'(n + 10), 64'd33);
    check_eq("pend_first_disp", 64'(disp()), 64'(model_disp(32'd100, 1'b1)));
    cur = model_disp(32'd100, 1'b1);
    tick();
    wait_idle(cur, n, stable);
    check_eq("pend_second_busy", 64'(n), 64'd33);
    check_eq("pend_second_hold", 64'(stable), 64'd1);
    check_eq("pend_second_disp", 64'(disp()), 64'(model_disp(32'd9, 1'b1)));
    cur = model_disp(32'd9, 1'b1);
    repeat (3) tick();
    check_eq("pend_no_third", 64'(bus.busy), 64'd0);

    // Reset at SHIFT cycle 16 of a pending-loaded run.
    do_write(32'd100, 1'b1);
    repeat (3) tick();
    do_write(32'd9, 1'b1);
    wait_idle(cur, n, stable);
    tick();
    repeat (15) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check_eq("pendrst_disp", 64'(disp()), 64'(ALL_BLANK));
    check_eq("pendrst_busy", 64'(bus.busy), 64'd0);
    check_eq("pendrst_ovf", 64'(bus.ovf), 64'd0);
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy !== 1'b0 || disp() !== ALL_BLANK) stable = 1'b0;
      tick();
    end
    check_eq("pendrst_quiet", 64'(stable), 64'd1);
    cur = ALL_BLANK;

    // Randomized single and pending-pair conversions.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0:       v1 = $urandom_range(0, 999);
        1:       v1 = $urandom;
        2:       v1 = $urandom_range(0, 99999999);
        default: v1 = ($urandom_range(0, 1) != 0) ? 32'd99999999 : 32'd100000000;
      endcase
      if ($urandom_range(0, 2) != 0) begin
        run_one("rnd", v1, $urandom_range(0, 1) != 0);
      end else begin
        v2 = $urandom;
        m2 = ($urandom_range(0, 1) != 0);
        t  = $urandom_range(0, 25);
        do_write(v1, 1'b1);
        repeat (t) tick();
        do_write(v2, m2);
        wait_idle(cur, n, stable);
        check_eq("rndp_first_busy", 64'(n + t + 1), 64'd33);
        check_eq("rndp_first_disp", 64'(disp()), 64'(model_disp(v1, 1'b1)));
        cur = model_disp(v1, 1'b1);
        tick();
        wait_idle(cur, n, stable);
        check_eq("rndp_second_busy", 64'(n), m2 ? 64'd33 : 64'd1);
        check_eq("rndp_second_hold", 64'(stable), 64'd1);
        check_eq("rndp_second_disp", 64'(disp()), 64'(model_disp(v2, m2)));
        check_eq("rndp_second_ovf", 64'(bus.ovf), 64'(model_ovf(v2, m2)));
        cur = model_disp(v2, m2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
